// File: rtl/fp_add_pipe.sv
// ---------------------------------------------------------------------------
// fp_add_pipe
// Three-stage pipelined floating-point adder with parametrised exponent and
// mantissa widths (default bf16: 1/8/7). Subnormal inputs are flushed to
// signed zero, outputs never go subnormal, and rounding is to nearest with
// ties to even. NaN / infinity / signed-zero handling is decided up front in
// the align stage and carried down the pipe as flags that override the
// arithmetic result at the end.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous reset, active low
//   a, b    operands, 1+EXP_W+MAN_W bits each
//   a_vld   operand A valid
//   b_vld   operand B valid
//   in_rdy  block can take an operand pair this cycle
//   z       sum
//   z_vld   sum valid
//   z_rdy   downstream accepts z
// ---------------------------------------------------------------------------
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic                   a_vld,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   b_vld,
    output logic                   in_rdy,
    output logic [EXP_W+MAN_W:0]   z,
    output logic                   z_vld,
    input  logic                   z_rdy
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;          // hidden, fraction, G, R, S
    localparam int AW  = MAN_W + 5;          // SW plus carry
    localparam int EW  = EXP_W + 2;          // signed exponent headroom
    localparam int LZW = $clog2(SW + 1);

    localparam logic [EXP_W-1:0]     EXP_MAX   = '1;
    localparam logic [EXP_W-1:0]     SHIFT_LIM = EXP_W'(MAN_W + 3);
    localparam logic signed [EW-1:0] E_INF     = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]         QNAN      = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic nan;
        logic inf;
        logic inf_sign;
        logic zero;
        logic zero_sign;
    } special_t;

    // Whole pipe stalls together: it may move whenever the output slot is
    // empty or is being drained this cycle.
    logic en;
    assign en     = !z_vld || z_rdy;
    assign in_rdy = en;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic                   sign_a, sign_b;
    logic [EXP_W-1:0]       exp_a, exp_b;
    logic [MAN_W-1:0]       man_a, man_b;
    logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W+MAN_W-1:0] mag_a, mag_b, l_mag, s_mag;
    logic                   swap, l_sign;
    logic [EXP_W-1:0]       l_exp, s_exp, diff;
    logic [MAN_W:0]         l_sig, s_sig;
    logic [SW-2:0]          s_ext, s_shift, ones;
    logic                   sticky;
    special_t               spec_d;

    // Zero/subnormal magnitudes collapse to 0 so the swap compare and the
    // hidden-bit recovery treat them as true zeros.
    always_comb begin
        sign_a = a[W-1];
        sign_b = b[W-1];
        exp_a  = a[W-2:MAN_W];
        exp_b  = b[W-2:MAN_W];
        man_a  = a[MAN_W-1:0];
        man_b  = b[MAN_W-1:0];
        a_zero = (exp_a == '0);
        b_zero = (exp_b == '0);
        a_inf  = (exp_a == EXP_MAX) && (man_a == '0);
        b_inf  = (exp_b == EXP_MAX) && (man_b == '0);
        a_nan  = (exp_a == EXP_MAX) && (man_a != '0);
        b_nan  = (exp_b == EXP_MAX) && (man_b != '0);
        mag_a  = a_zero ? '0 : {exp_a, man_a};
        mag_b  = b_zero ? '0 : {exp_b, man_b};
        swap   = (mag_b > mag_a);
        l_mag  = swap ? mag_b : mag_a;
        s_mag  = swap ? mag_a : mag_b;
        l_sign = swap ? sign_b : sign_a;
        l_exp  = l_mag[EXP_W+MAN_W-1:MAN_W];
        s_exp  = s_mag[EXP_W+MAN_W-1:MAN_W];
        l_sig  = {(l_exp != '0), l_mag[MAN_W-1:0]};
        s_sig  = {(s_exp != '0), s_mag[MAN_W-1:0]};
        diff   = l_exp - s_exp;
        s_ext  = {s_sig, 2'b00};
        ones   = '1;
        // Past MAN_W+3 places every bit (including R) is gone; only sticky survives.
        if (diff >= SHIFT_LIM) begin
            s_shift = '0;
            sticky  = |s_sig;
        end else begin
            s_shift = s_ext >> diff;
            sticky  = |(s_ext & ~(ones << diff));
        end
        spec_d.nan       = a_nan || b_nan || (a_inf && b_inf && (sign_a != sign_b));
        spec_d.inf       = a_inf || b_inf;
        spec_d.inf_sign  = a_inf ? sign_a : sign_b;
        spec_d.zero      = a_zero && b_zero;
        spec_d.zero_sign = sign_a && sign_b;
    end

    logic             s1_vld, s1_sign, s1_sub;
    logic [EXP_W-1:0] s1_exp;
    logic [SW-1:0]    s1_sig_l, s1_sig_s;
    special_t         s1_spec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sub   <= 1'b0;
            s1_exp   <= '0;
            s1_sig_l <= '0;
            s1_sig_s <= '0;
            s1_spec  <= '0;
        end else if (en) begin
            s1_vld   <= a_vld && b_vld;
            s1_sign  <= l_sign;
            s1_sub   <= sign_a ^ sign_b;
            s1_exp   <= l_exp;
            s1_sig_l <= {l_sig, 3'b000};
            s1_sig_s <= {s_shift, sticky};
            s1_spec  <= spec_d;
        end
    end

    // ---------------- S2: significand add / subtract ----------------
    // The swap guarantees the large operand dominates, so subtraction never
    // goes negative.
    logic [AW-1:0]    s2_sum;
    logic             s2_vld, s2_sign;
    logic [EXP_W-1:0] s2_exp;
    special_t         s2_spec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_exp  <= '0;
            s2_sum  <= '0;
            s2_spec <= '0;
        end else if (en) begin
            s2_vld  <= s1_vld;
            s2_sign <= s1_sign;
            s2_exp  <= s1_exp;
            s2_sum  <= s1_sub ? ({1'b0, s1_sig_l} - {1'b0, s1_sig_s})
                              : ({1'b0, s1_sig_l} + {1'b0, s1_sig_s});
            s2_spec <= s1_spec;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    function automatic logic [LZW-1:0] count_lz(input logic [SW-1:0] v);
        count_lz = LZW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) count_lz = LZW'(SW - 1 - i);
        end
    endfunction

    logic [LZW-1:0]         lz;
    logic [SW-1:0]          norm;
    logic signed [EW-1:0]   e_norm, e_fin;
    logic                   inc;
    logic [MAN_W+1:0]       rounded;
    logic [MAN_W-1:0]       frac;
    logic [W-1:0]           result;

    // On carry-out the dropped bit folds into sticky so rounding stays exact.
    always_comb begin
        lz = count_lz(s2_sum[SW-1:0]);
        if (s2_sum[AW-1]) begin
            norm   = {s2_sum[AW-1:2], s2_sum[1] | s2_sum[0]};
            e_norm = {2'b00, s2_exp} + EW'(1);
        end else begin
            norm   = s2_sum[SW-1:0] << lz;
            e_norm = {2'b00, s2_exp} - EW'(lz);
        end
        inc     = norm[2] && (norm[1] || norm[0] || norm[3]);
        rounded = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(inc);
        if (rounded[MAN_W+1]) begin
            e_fin = e_norm + EW'(1);
            frac  = rounded[MAN_W:1];
        end else begin
            e_fin = e_norm;
            frac  = rounded[MAN_W-1:0];
        end
        if (s2_spec.nan)
            result = QNAN;
        else if (s2_spec.inf)
            result = {s2_spec.inf_sign, EXP_MAX, {MAN_W{1'b0}}};
        else if (s2_spec.zero)
            result = {s2_spec.zero_sign, {(W-1){1'b0}}};
        else if (s2_sum == '0)
            result = '0;
        else if (e_fin >= E_INF)
            result = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
        else if (e_fin[EW-1] || (e_fin == '0))
            result = {s2_sign, {(W-1){1'b0}}};
        else
            result = {s2_sign, e_fin[EXP_W-1:0], frac};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_vld <= 1'b0;
            z     <= '0;
        end else if (en) begin
            z_vld <= s2_vld;
            if (s2_vld) z <= result;
        end
    end

endmodule
